// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM stage bus: upstream handshake and payload, downstream handshake and
// registered payload, flush and the stall monitor.
interface ex_mem_pipe_stage_if #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int MEMC_W = 2,
  parameter int WBC_W  = 2,
  parameter int CNT_W  = 16
);
  logic              ex_valid;
  logic              ex_ready;
  logic [RD_W-1:0]   ex_rd;
  logic [MEMC_W-1:0] ex_mem_control;
  logic [WBC_W-1:0]  ex_wb_control;
  logic              ex_branch;
  logic [XLEN-1:0]   ex_rs2;
  logic [XLEN-1:0]   ex_result;
  logic [XLEN-1:0]   ex_branch_address;
  logic              flush;
  logic              mem_ready;
  logic              mem_valid;
  logic [RD_W-1:0]   mem_rd;
  logic [MEMC_W-1:0] mem_mem_control;
  logic [WBC_W-1:0]  mem_wb_control;
  logic              mem_branch;
  logic [XLEN-1:0]   mem_write_data;
  logic [XLEN-1:0]   mem_result;
  logic [XLEN-1:0]   mem_branch_address;
  logic [CNT_W-1:0]  stall_count;

  // master = the pipeline around the stage, slave = the stage itself
  modport master (
    output ex_valid, ex_rd, ex_mem_control, ex_wb_control, ex_branch, ex_rs2,
           ex_result, ex_branch_address, flush, mem_ready,
    input  ex_ready, mem_valid, mem_rd, mem_mem_control, mem_wb_control, mem_branch,
           mem_write_data, mem_result, mem_branch_address, stall_count
  );
  modport slave (
    input  ex_valid, ex_rd, ex_mem_control, ex_wb_control, ex_branch, ex_rs2,
           ex_result, ex_branch_address, flush, mem_ready,
    output ex_ready, mem_valid, mem_rd, mem_mem_control, mem_wb_control, mem_branch,
           mem_write_data, mem_result, mem_branch_address, stall_count
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, load-gated data registers and a saturating stall counter.
module ex_mem_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int MEMC_W = 2,
  parameter int WBC_W  = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
  ex_mem_pipe_stage_if.slave bus
);
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [MEMC_W-1:0] memc;
    logic [WBC_W-1:0]  wbc;
    logic              br;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   baddr;
  } entry_t;

  // bit0 = main entry valid, bit1 = skid entry valid; both read straight off the register
  typedef enum logic [1:0] {S_EMPTY = 2'b00, S_FULL = 2'b01, S_SKID = 2'b11} state_e;

  state_e           state, state_nx;
  entry_t           in_e, main_q, skid_q, main_d;
  logic             rdy, accept, rel;
  logic             load_main, load_skid, from_skid;
  logic [CNT_W-1:0] stall_q;

  assign in_e = '{rd: bus.ex_rd, memc: bus.ex_mem_control, wbc: bus.ex_wb_control,
                  br: bus.ex_branch, rs2: bus.ex_rs2, result: bus.ex_result,
                  baddr: bus.ex_branch_address};

  generate
    if (SKID != 0) begin : g_skid
      assign rdy = ~state[1];
    end else begin : g_noskid
      assign rdy = bus.mem_ready | ~state[0];
    end
  endgenerate

  assign accept = bus.ex_valid & rdy;
  assign rel    = state[0] & bus.mem_ready;
  assign main_d = from_skid ? skid_q : in_e;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_EMPTY;
    else       state <= state_nx;

  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (bus.flush) state_nx = S_EMPTY;
    else begin
      case (state)
        S_EMPTY: if (accept) begin state_nx = S_FULL; load_main = 1'b1; end
        S_FULL: begin
          if (accept && rel)  load_main = 1'b1;
          else if (accept)    begin state_nx = S_SKID; load_skid = 1'b1; end
          else if (rel)       state_nx = S_EMPTY;
        end
        S_SKID: if (rel) begin state_nx = S_FULL; load_main = 1'b1; from_skid = 1'b1; end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Data fields only move on a transfer; control fields drop whenever main goes invalid
  always_ff @(posedge clk or posedge reset)
    if (reset) main_q <= '0;
    else begin
      if (load_main) main_q <= main_d;
      if (!state_nx[0]) begin
        main_q.memc <= '0;
        main_q.wbc  <= '0;
        main_q.br   <= 1'b0;
      end
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) skid_q <= '0;
    else begin
      if (load_skid) skid_q <= in_e;
      if (!state_nx[1]) begin
        skid_q.memc <= '0;
        skid_q.wbc  <= '0;
        skid_q.br   <= 1'b0;
      end
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) stall_q <= '0;
    else if (state[0] && !bus.mem_ready && stall_q != {CNT_W{1'b1}})
      stall_q <= stall_q + CNT_W'(1);

  assign bus.ex_ready           = rdy;
  assign bus.mem_valid          = state[0];
  assign bus.mem_rd             = main_q.rd;
  assign bus.mem_mem_control    = main_q.memc;
  assign bus.mem_wb_control     = main_q.wbc;
  assign bus.mem_branch         = main_q.br;
  assign bus.mem_write_data     = main_q.rs2;
  assign bus.mem_result         = main_q.result;
  assign bus.mem_branch_address = main_q.baddr;
  assign bus.stall_count        = stall_q;
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench: skid-buffered stage (16-bit and 2-bit counters) plus a
// no-skid build, all fed the same upstream/downstream stimulus.
module tb_ex_mem_pipe_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage_if #(.CNT_W(16)) if_m();
  ex_mem_pipe_stage_if #(.CNT_W(2))  if_s();
  ex_mem_pipe_stage_if #(.CNT_W(16)) if_z();

  ex_mem_pipe_stage #(.SKID(1), .CNT_W(16)) dut_m (.clk(clk), .reset(reset), .bus(if_m.slave));
  ex_mem_pipe_stage #(.SKID(1), .CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));
  ex_mem_pipe_stage #(.SKID(0), .CNT_W(16)) dut_z (.clk(clk), .reset(reset), .bus(if_z.slave));

  assign if_s.ex_valid = if_m.ex_valid;                   assign if_z.ex_valid = if_m.ex_valid;
  assign if_s.ex_rd = if_m.ex_rd;                         assign if_z.ex_rd = if_m.ex_rd;
  assign if_s.ex_mem_control = if_m.ex_mem_control;       assign if_z.ex_mem_control = if_m.ex_mem_control;
  assign if_s.ex_wb_control = if_m.ex_wb_control;         assign if_z.ex_wb_control = if_m.ex_wb_control;
  assign if_s.ex_branch = if_m.ex_branch;                 assign if_z.ex_branch = if_m.ex_branch;
  assign if_s.ex_rs2 = if_m.ex_rs2;                       assign if_z.ex_rs2 = if_m.ex_rs2;
  assign if_s.ex_result = if_m.ex_result;                 assign if_z.ex_result = if_m.ex_result;
  assign if_s.ex_branch_address = if_m.ex_branch_address; assign if_z.ex_branch_address = if_m.ex_branch_address;
  assign if_s.flush = if_m.flush;                         assign if_z.flush = if_m.flush;
  assign if_s.mem_ready = if_m.mem_ready;                 assign if_z.mem_ready = if_m.mem_ready;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Payload side fields are derived from rd/result so each word is distinguishable
  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res);
    if_m.ex_valid          = v;
    if_m.ex_rd             = rd;
    if_m.ex_result         = res;
    if_m.ex_rs2            = res ^ 32'hFFFF_0000;
    if_m.ex_branch_address = res + 32'd4;
    if_m.ex_mem_control    = rd[1:0];
    if_m.ex_wb_control     = ~rd[1:0];
    if_m.ex_branch         = rd[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0);
    if_m.flush = 1'b0;
    if_m.mem_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    if_m.flush = 1'b0;
    if_m.mem_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_run++; if (if_m.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h exp=0", if_m.mem_valid); end
    n_run++; if (if_m.mem_result !== 32'd0) begin n_fail++; $display("FAIL rst_result got=%h exp=0", if_m.mem_result); end
    n_run++; if (if_m.stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_stall got=%0d exp=0", if_m.stall_count); end
    n_run++; if (if_m.ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0h exp=1", if_m.ex_ready); end
    drive(1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    n_run++; if (if_m.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_held_valid got=%0h exp=0", if_m.mem_valid); end
    n_run++; if (if_z.ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_noskid got=%0h exp=1", if_z.ex_ready); end
    drive(1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_latency();
    if_m.mem_ready = 1'b1;
    drive(1'b1, 5'd5, 32'h1234_5678);
    step();
    drive(1'b0, 5'd0, 32'd0);
    n_run++; if (if_m.mem_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got=%0h exp=1", if_m.mem_valid); end
    n_run++; if (if_m.mem_result !== 32'h1234_5678) begin n_fail++; $display("FAIL lat_result got=%h exp=12345678", if_m.mem_result); end
    n_run++; if (if_m.mem_rd !== 5'd5) begin n_fail++; $display("FAIL lat_rd got=%0d exp=5", if_m.mem_rd); end
    n_run++; if (if_m.mem_write_data !== 32'hEDCB_5678) begin n_fail++; $display("FAIL lat_wdata got=%h exp=edcb5678", if_m.mem_write_data); end
    n_run++; if (if_m.mem_branch_address !== 32'h1234_567C) begin n_fail++; $display("FAIL lat_baddr got=%h exp=1234567c", if_m.mem_branch_address); end
    n_run++; if (if_m.mem_mem_control !== 2'b01 || if_m.mem_wb_control !== 2'b10 || if_m.mem_branch !== 1'b1) begin
      n_fail++; $display("FAIL lat_ctrl got=%b/%b/%b exp=01/10/1", if_m.mem_mem_control, if_m.mem_wb_control, if_m.mem_branch); end
    step();
    n_run++; if (if_m.mem_valid !== 1'b0 || if_m.mem_mem_control !== 2'b00 || if_m.mem_branch !== 1'b0) begin
      n_fail++; $display("FAIL drain_ctrl got=%0h/%b/%0h exp=0/00/0", if_m.mem_valid, if_m.mem_mem_control, if_m.mem_branch); end
    n_run++; if (if_m.mem_result !== 32'h1234_5678) begin n_fail++; $display("FAIL drain_hold got=%h exp=12345678", if_m.mem_result); end
  endtask

  task automatic test_skid_order();
    if_m.mem_ready = 1'b0;
    drive(1'b1, 5'd1, 32'hA0A0_0001);
    step();
    n_run++; if (if_m.mem_result !== 32'hA0A0_0001 || if_m.ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL skid_a got=%h/%0h exp=a0a00001/1", if_m.mem_result, if_m.ex_ready); end
    drive(1'b1, 5'd2, 32'hB0B0_0002);
    step();
    n_run++; if (if_m.ex_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready got=%0h exp=0", if_m.ex_ready); end
    n_run++; if (if_m.mem_result !== 32'hA0A0_0001) begin n_fail++; $display("FAIL skid_hold1 got=%h exp=a0a00001", if_m.mem_result); end
    drive(1'b1, 5'd3, 32'hC0C0_0003);
    step();
    n_run++; if (if_m.mem_result !== 32'hA0A0_0001 || if_m.mem_rd !== 5'd1 || if_m.ex_ready !== 1'b0) begin
      n_fail++; $display("FAIL skid_hold2 got=%h/%0d/%0h exp=a0a00001/1/0", if_m.mem_result, if_m.mem_rd, if_m.ex_ready); end
    if_m.mem_ready = 1'b1;
    step();
    n_run++; if (if_m.mem_result !== 32'hB0B0_0002 || if_m.mem_rd !== 5'd2 || if_m.ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL order_b got=%h/%0d/%0h exp=b0b00002/2/1", if_m.mem_result, if_m.mem_rd, if_m.ex_ready); end
    step();
    drive(1'b0, 5'd0, 32'd0);
    n_run++; if (if_m.mem_result !== 32'hC0C0_0003 || if_m.mem_rd !== 5'd3 || if_m.mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL order_c got=%h/%0d/%0h exp=c0c00003/3/1", if_m.mem_result, if_m.mem_rd, if_m.mem_valid); end
    step();
    n_run++; if (if_m.mem_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty got=%0h exp=0", if_m.mem_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 5'd4, 32'h5757_0004);
    step();
    drive(1'b0, 5'd0, 32'd0);
    repeat (5) step();
    n_run++; if (if_m.stall_count !== 16'd5) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=5", if_m.stall_count); end
    n_run++; if (if_s.stall_count !== 2'd3) begin n_fail++; $display("FAIL stall_sat got=%0d exp=3", if_s.stall_count); end
    n_run++; if (if_m.mem_valid !== 1'b1 || if_m.mem_result !== 32'h5757_0004 || if_m.mem_rd !== 5'd4) begin
      n_fail++; $display("FAIL stall_hold got=%0h/%h/%0d exp=1/57570004/4", if_m.mem_valid, if_m.mem_result, if_m.mem_rd); end
    if_m.mem_ready = 1'b1;
    step();
    n_run++; if (if_m.mem_valid !== 1'b0 || if_m.stall_count !== 16'd5) begin
      n_fail++; $display("FAIL stall_release got=%0h/%0d exp=0/5", if_m.mem_valid, if_m.stall_count); end
  endtask

  task automatic test_flush();
    if_m.mem_ready = 1'b0;
    drive(1'b1, 5'd3, 32'hF0F0_00AA);
    step();
    drive(1'b1, 5'd6, 32'hF0F0_00BB);
    step();
    n_run++; if (if_m.ex_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_ready got=%0h exp=0", if_m.ex_ready); end
    if_m.flush = 1'b1;
    drive(1'b1, 5'd7, 32'hF0F0_00DD);
    step();
    if_m.flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    n_run++; if (if_m.mem_valid !== 1'b0 || if_m.ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state got=%0h/%0h exp=0/1", if_m.mem_valid, if_m.ex_ready); end
    n_run++; if (if_m.mem_mem_control !== 2'b00 || if_m.mem_wb_control !== 2'b00 || if_m.mem_branch !== 1'b0) begin
      n_fail++; $display("FAIL flush_ctrl got=%b/%b/%b exp=00/00/0", if_m.mem_mem_control, if_m.mem_wb_control, if_m.mem_branch); end
    n_run++; if (if_m.mem_result !== 32'hF0F0_00AA) begin n_fail++; $display("FAIL flush_data got=%h exp=f0f000aa", if_m.mem_result); end
    n_run++; if (if_m.stall_count !== 16'd7) begin n_fail++; $display("FAIL flush_stall got=%0d exp=7", if_m.stall_count); end
    step();
    n_run++; if (if_m.mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got=%0h exp=0", if_m.mem_valid); end
  endtask

  task automatic test_async_reset();
    if_m.mem_ready = 1'b1;
    drive(1'b1, 5'd9, 32'h0E0E_0009);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    n_run++; if (if_m.mem_valid !== 1'b0 || if_m.mem_result !== 32'd0 || if_m.mem_rd !== 5'd0) begin
      n_fail++; $display("FAIL areset_out got=%0h/%h/%0d exp=0/0/0", if_m.mem_valid, if_m.mem_result, if_m.mem_rd); end
    n_run++; if (if_m.stall_count !== 16'd0 || if_m.ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_misc got=%0d/%0h exp=0/1", if_m.stall_count, if_m.ex_ready); end
    #1 reset = 1'b0;
    drive(1'b1, 5'd10, 32'h0F0F_000A);
    step();
    drive(1'b0, 5'd0, 32'd0);
    n_run++; if (if_m.mem_valid !== 1'b1 || if_m.mem_result !== 32'h0F0F_000A || if_m.mem_rd !== 5'd10) begin
      n_fail++; $display("FAIL areset_after got=%0h/%h/%0d exp=1/0f0f000a/10", if_m.mem_valid, if_m.mem_result, if_m.mem_rd); end
    step();
  endtask

  // No-skid build: mem_ready toggles 0,1,0,1,...; ready/result sequence worked out by hand
  task automatic test_back_to_back();
    logic        exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          exp_w   [6] = '{0, 1, 1, 2, 2, 3};
    int          idx = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if_m.mem_ready = (i % 2) == 1;
      drive(1'b1, 5'(16 + idx), 32'h5000_0000 + 32'(idx));
      #1;
      n_run++; if (if_z.ex_ready !== exp_rdy[i]) begin
        n_fail++; $display("FAIL b2b_ready[%0d] got=%0h exp=%0h", i, if_z.ex_ready, exp_rdy[i]); end
      step();
      n_run++; if (if_z.mem_valid !== 1'b1 || if_z.mem_result !== 32'h5000_0000 + 32'(exp_w[i])) begin
        n_fail++; $display("FAIL b2b_out[%0d] got=%0h/%h exp=1/%h", i, if_z.mem_valid, if_z.mem_result, 32'h5000_0000 + 32'(exp_w[i])); end
      if (exp_rdy[i]) idx++;
    end
    drive(1'b0, 5'd0, 32'd0);
    if_m.mem_ready = 1'b1;
    step();
    n_run++; if (if_z.mem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%0h exp=0", if_z.mem_valid); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_skid_order();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
- Parametrised EX->MEM pipeline stage that replaces the plain EX/MEM register.
- Adds a valid/ready handshake, a 2-entry skid buffer so upstream ready is registered, synchronous flush, and power-aware data gating: data registers load only on an accepted transfer.
- Adds a saturating stall counter for performance monitoring.
- Sits between the execute stage (ALU/branch unit) and the data-memory stage.

Parameters:
- XLEN, 32, width of rs2/result/branch_address datapath
- RD_W, 5, destination register index width
- MEMC_W, 2, memory control field width
- WBC_W, 2, writeback control field width
- SKID, 1, 1 = 2-entry skid buffer with registered ex_ready; 0 = single register with combinational ex_ready
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX presents a valid instruction
- ex_ready  out  1  stage can accept this cycle
- ex_rd  in  RD_W  destination register
- ex_mem_control  in  MEMC_W  memory control
- ex_wb_control  in  WBC_W  writeback control
- ex_branch  in  1  branch-taken flag
- ex_rs2  in  XLEN  store data
- ex_result  in  XLEN  ALU result
- ex_branch_address  in  XLEN  branch target
- flush  in  1  kill all held and incoming instructions
- mem_ready  in  1  MEM stage accepts this cycle
- mem_valid  out  1  output holds a valid instruction
- mem_rd  out  RD_W  registered ex_rd
- mem_mem_control  out  MEMC_W  registered control, forced 0 when mem_valid=0
- mem_wb_control  out  WBC_W  registered control, forced 0 when mem_valid=0
- mem_branch  out  1  registered branch flag, forced 0 when mem_valid=0
- mem_write_data  out  XLEN  registered ex_rs2
- mem_result  out  XLEN  registered ex_result
- mem_branch_address  out  XLEN  registered ex_branch_address
- stall_count  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - every mem_* output, mem_valid, the skid entry and stall_count are 0;
  - ex_ready=1.
- Handshake:
  - accept = ex_valid & ex_ready;
  - release = mem_valid & mem_ready.
  - Output fields are stable while mem_valid=1 and mem_ready=0.
- SKID=1 states:
  - EMPTY (main invalid): accept -> FULL, main loads the input.
  - FULL:
    - accept & release -> FULL, main loads the input;
    - accept & !release -> SKID, skid loads the input;
    - !accept & release -> EMPTY;
    - else hold.
  - SKID: ex_ready=0.
    - release -> FULL, main loads skid, skid cleared;
    - else hold.
  - ex_ready = !skid_valid, taken straight from a register.
- SKID=0:
  - ex_ready = mem_ready | !mem_valid (combinational);
  - no SKID state.
- Latency: an input accepted in cycle N appears on the outputs at edge N+1 when the stage was EMPTY, or FULL with release. Order is strictly FIFO.
- Data gating:
  - XLEN and rd registers load only on a transfer into that entry and otherwise hold their value. They are never zeroed except by reset.
  - Control outputs (mem_mem_control, mem_wb_control, mem_branch) are cleared whenever the main entry goes invalid.
- Flush (synchronous):
  - On the next edge, mem_valid=0, skid invalid and control outputs 0. Data registers hold.
  - Any same-cycle accept is discarded.
  - Flush has priority over accept and release.
- stall_count:
  - increments on every edge with mem_valid & !mem_ready;
  - saturates at 2^CNT_W-1;
  - cleared only by reset; flush does not clear it.
- Reset mid-operation: all in-flight entries are lost immediately, without waiting for a clock edge.

Test Plan:
- After reset, ex_valid=1, ex_result=0x1234_5678, ex_rd=5, mem_ready=1 -> at the next edge mem_valid=1, mem_result=0x12345678, mem_rd=5. One-cycle latency.
- Stream A,B,C with mem_ready=0 from the cycle A arrives:
  - A sits in main, B goes into skid, ex_ready=0, C is held upstream;
  - raise mem_ready -> outputs A, B, C in order, with no loss or duplication.
- Hold mem_ready=0 with mem_valid=1 for 5 cycles -> stall_count=5, outputs unchanged. With CNT_W=2, 5 cycles -> stall_count=3 (saturated).
- SKID state plus flush with ex_valid=1 -> next edge mem_valid=0, mem_mem_control=0, mem_wb_control=0, mem_branch=0, ex_ready=1. mem_result retains its old value.
- Assert reset asynchronously mid-stream, between clock edges -> all outputs 0 immediately. After release, ex_ready=1 and the first accepted word passes through correctly.
- SKID=0 build, back-to-back transfers with mem_ready toggling every cycle -> ex_ready tracks mem_ready | !mem_valid combinationally, and throughput matches mem_ready duty.
